// File: rtl/vga_sync_gen.sv
// Raster timing generator: pixel coordinates, active-video flag and HSYNC/VSYNC.
// Define VGA_SYNC_DELAY_EN to delay oHS/oVS/oActive by one extra iVGA_CLK register.
module vga_sync_gen #(
  parameter int unsigned H_VISIBLE   = 640,
  parameter int unsigned H_FRONT     = 16,
  parameter int unsigned H_SYNC      = 96,
  parameter int unsigned H_BACK      = 48,
  parameter int unsigned V_VISIBLE   = 480,
  parameter int unsigned V_FRONT     = 10,
  parameter int unsigned V_SYNC      = 2,
  parameter int unsigned V_BACK      = 33,
  parameter int unsigned SYNC_ACTIVE = 0
) (
  input  logic       iVGA_CLK,
  input  logic       iRST,
  input  logic       iPixEn,
  output logic [9:0] oVGA_X,
  output logic [9:0] oVGA_Y,
  output logic       oActive,
  output logic       oHS,
  output logic       oVS,
  output logic       oLineStart,
  output logic       oFrameStart
);

  localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
  localparam logic [9:0] H_FP_START = 10'(H_VISIBLE);
  localparam logic [9:0] H_SY_START = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] H_BP_START = 10'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
  localparam logic [9:0] V_FP_START = 10'(V_VISIBLE);
  localparam logic [9:0] V_SY_START = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] V_BP_START = 10'(V_VISIBLE + V_FRONT + V_SYNC);

  localparam logic SYNC_ON  = 1'(SYNC_ACTIVE);
  localparam logic SYNC_OFF = ~SYNC_ON;

  typedef enum logic [1:0] {
    RGN_ACTIVE = 2'd0,
    RGN_FRONT  = 2'd1,
    RGN_SYNC   = 2'd2,
    RGN_BACK   = 2'd3
  } region_t;

  function automatic region_t decode_region(
    input logic [9:0] cnt,
    input logic [9:0] fp_start,
    input logic [9:0] sy_start,
    input logic [9:0] bp_start
  );
    region_t rgn;
    if (cnt < fp_start) begin
      rgn = RGN_ACTIVE;
    end else if (cnt < sy_start) begin
      rgn = RGN_FRONT;
    end else if (cnt < bp_start) begin
      rgn = RGN_SYNC;
    end else begin
      rgn = RGN_BACK;
    end
    return rgn;
  endfunction

  logic [9:0] r_hcnt;
  logic [9:0] r_vcnt;
  region_t    r_hstate;
  region_t    r_vstate;
  logic [9:0] w_hcnt_next;
  logic [9:0] w_vcnt_next;
  region_t    w_hstate_next;
  region_t    w_vstate_next;

  logic [9:0] r_x;
  logic [9:0] r_y;
  logic       r_active;
  logic       r_hs;
  logic       r_vs;
  logic       r_line_start;
  logic       r_frame_start;

  // Next counter values; vcnt only moves on the horizontal wrap.
  always_comb begin
    w_hcnt_next = r_hcnt + 10'd1;
    w_vcnt_next = r_vcnt;
    if (r_hcnt == H_LAST) begin
      w_hcnt_next = 10'd0;
      if (r_vcnt == V_LAST) begin
        w_vcnt_next = 10'd0;
      end else begin
        w_vcnt_next = r_vcnt + 10'd1;
      end
    end else begin
      w_hcnt_next = r_hcnt + 10'd1;
    end
  end

  // Region state machines track the region of the counter value being loaded.
  always_comb begin
    w_hstate_next = r_hstate;
    w_vstate_next = r_vstate;
    if (iPixEn) begin
      w_hstate_next = decode_region(w_hcnt_next, H_FP_START, H_SY_START, H_BP_START);
      w_vstate_next = decode_region(w_vcnt_next, V_FP_START, V_SY_START, V_BP_START);
    end else begin
      w_hstate_next = r_hstate;
      w_vstate_next = r_vstate;
    end
  end

  // Counter and region state registers.
  always_ff @(posedge iVGA_CLK) begin
    if (iRST) begin
      r_hcnt   <= H_LAST;
      r_vcnt   <= V_LAST;
      r_hstate <= RGN_BACK;
      r_vstate <= RGN_BACK;
    end else if (iPixEn) begin
      r_hcnt   <= w_hcnt_next;
      r_vcnt   <= w_vcnt_next;
      r_hstate <= w_hstate_next;
      r_vstate <= w_vstate_next;
    end
  end

  // Outputs load together with the counters, so flags line up with X/Y.
  always_ff @(posedge iVGA_CLK) begin
    if (iRST) begin
      r_x           <= 10'd0;
      r_y           <= 10'd0;
      r_active      <= 1'b0;
      r_hs          <= SYNC_OFF;
      r_vs          <= SYNC_OFF;
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
    end else begin
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
      if (iPixEn) begin
        r_x           <= w_hcnt_next;
        r_y           <= w_vcnt_next;
        r_active      <= (w_hstate_next == RGN_ACTIVE) && (w_vstate_next == RGN_ACTIVE);
        r_hs          <= (w_hstate_next == RGN_SYNC) ? SYNC_ON : SYNC_OFF;
        r_vs          <= (w_vstate_next == RGN_SYNC) ? SYNC_ON : SYNC_OFF;
        r_line_start  <= (w_hcnt_next == 10'd0);
        r_frame_start <= (w_hcnt_next == 10'd0) && (w_vcnt_next == 10'd0);
      end
    end
  end

  assign oVGA_X      = r_x;
  assign oVGA_Y      = r_y;
  assign oLineStart  = r_line_start;
  assign oFrameStart = r_frame_start;

`ifdef VGA_SYNC_DELAY_EN
  logic r_active_d;
  logic r_hs_d;
  logic r_vs_d;

  // Extra stage matching the drive stage's registered RGB; runs every clock.
  always_ff @(posedge iVGA_CLK) begin
    if (iRST) begin
      r_active_d <= 1'b0;
      r_hs_d     <= SYNC_OFF;
      r_vs_d     <= SYNC_OFF;
    end else begin
      r_active_d <= r_active;
      r_hs_d     <= r_hs;
      r_vs_d     <= r_vs;
    end
  end

  assign oActive = r_active_d;
  assign oHS     = r_hs_d;
  assign oVS     = r_vs_d;
`else
  assign oActive = r_active;
  assign oHS     = r_hs;
  assign oVS     = r_vs;
`endif

endmodule

// File: tb/tb_vga_sync_gen.sv
// Self-checking bench for vga_sync_gen: vector table, counted windows and a
// position-based reference model on a default and a small fast-frame instance.
module tb_vga_sync_gen;

`ifdef VGA_SYNC_DELAY_EN
  localparam bit DLY = 1'b1;
`else
  localparam bit DLY = 1'b0;
`endif

  // Small instance: fast frames and active-high sync polarity.
  localparam int SHV = 16, SHF = 4, SHS = 6, SHB = 4;
  localparam int SVV = 12, SVF = 2, SVS = 2, SVB = 3;
  localparam int D_TOTAL = 800 * 525;
  localparam int S_TOTAL = (SHV + SHF + SHS + SHB) * (SVV + SVF + SVS + SVB);

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic       act;
    logic       hs;
    logic       vs;
    logic       ls;
    logic       fs;
  } out_t;

  typedef struct {
    bit   rst;
    bit   pe;
    out_t exp;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       pe;
  logic [9:0] d_x, d_y, s_x, s_y;
  logic       d_act, d_hs, d_vs, d_ls, d_fs;
  logic       s_act, s_hs, s_vs, s_ls, s_fs;

  int checks = 0;
  int errors = 0;
  int p_d, p_s;
  out_t prev_d, prev_s;

  vga_sync_gen dut (
    .iVGA_CLK(clk), .iRST(rst), .iPixEn(pe),
    .oVGA_X(d_x), .oVGA_Y(d_y), .oActive(d_act), .oHS(d_hs), .oVS(d_vs),
    .oLineStart(d_ls), .oFrameStart(d_fs)
  );

  vga_sync_gen #(
    .H_VISIBLE(SHV), .H_FRONT(SHF), .H_SYNC(SHS), .H_BACK(SHB),
    .V_VISIBLE(SVV), .V_FRONT(SVF), .V_SYNC(SVS), .V_BACK(SVB),
    .SYNC_ACTIVE(1)
  ) dut_s (
    .iVGA_CLK(clk), .iRST(rst), .iPixEn(pe),
    .oVGA_X(s_x), .oVGA_Y(s_y), .oActive(s_act), .oHS(s_hs), .oVS(s_vs),
    .oLineStart(s_ls), .oFrameStart(s_fs)
  );

  function automatic out_t mk(int x, int y, bit a, bit h, bit v, bit l, bit f);
    out_t o;
    o.x = 10'(x); o.y = 10'(y);
    o.act = a; o.hs = h; o.vs = v; o.ls = l; o.fs = f;
    return o;
  endfunction

  // Expected outputs from the linear strobe position p within the frame (p<0: no strobe since reset).
  function automatic out_t model(int p, bit strobe, int hv, int hf, int hsw, int hb,
                                 int vv, int vf, int vsw, int vb, bit sa);
    int ht, x, y;
    bit a, h, v;
    ht = hv + hf + hsw + hb;
    if (p < 0) return mk(0, 0, 1'b0, !sa, !sa, 1'b0, 1'b0);
    x = p % ht;
    y = p / ht;
    a = (x < hv) && (y < vv);
    h = (x >= hv + hf && x < hv + hf + hsw) ? sa : !sa;
    v = (y >= vv + vf && y < vv + vf + vsw) ? sa : !sa;
    return mk(x, y, a, h, v, strobe && (x == 0), strobe && (p == 0));
  endfunction

  function automatic out_t shift(out_t cur, out_t prev, bit r);
    out_t o;
    o = cur;
    if (DLY && !r) begin
      o.act = prev.act; o.hs = prev.hs; o.vs = prev.vs;
    end
    return o;
  endfunction

  function automatic out_t get_d();
    return mk(int'(d_x), int'(d_y), d_act, d_hs, d_vs, d_ls, d_fs);
  endfunction

  function automatic out_t get_s();
    return mk(int'(s_x), int'(s_y), s_act, s_hs, s_vs, s_ls, s_fs);
  endfunction

  task automatic check(input string name, input out_t got, input out_t exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got x=%0d y=%0d a=%b hs=%b vs=%b ls=%b fs=%b exp x=%0d y=%0d a=%b hs=%b vs=%b ls=%b fs=%b",
               name, $time, got.x, got.y, got.act, got.hs, got.vs, got.ls, got.fs,
               exp.x, exp.y, exp.act, exp.hs, exp.vs, exp.ls, exp.fs);
    end
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", name, got, exp);
    end
  endtask

  // One clock: drive, sample 1ns after the edge, advance both models and compare.
  task automatic step(input bit r, input bit e);
    out_t cur;
    rst = r;
    pe  = e;
    @(posedge clk);
    #1;
    if (r) begin
      p_d = -1; p_s = -1;
    end else if (e) begin
      p_d = (p_d + 1) % D_TOTAL;
      p_s = (p_s + 1) % S_TOTAL;
    end
    cur = model(p_d, !r && e, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0);
    check("model_def", get_d(), shift(cur, prev_d, r));
    prev_d = cur;
    cur = model(p_s, !r && e, SHV, SHF, SHS, SHB, SVV, SVF, SVS, SVB, 1'b1);
    check("model_small", get_s(), shift(cur, prev_s, r));
    prev_s = cur;
  endtask

  vec_t tbl[9];
  out_t prev_row, rst_val;
  int hs_cnt, act_cnt, ls_cnt, fs_cnt, vs_cnt;
  bit last_ls, last_fs, last_sls;

  initial begin
    rst = 1'b1;
    pe  = 1'b0;
    p_d = -1;
    p_s = -1;
    rst_val = mk(0, 0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    prev_d  = rst_val;
    prev_s  = mk(0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    tbl[0] = '{rst: 1'b1, pe: 1'b0, exp: mk(0, 0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0)};
    tbl[1] = '{rst: 1'b0, pe: 1'b1, exp: mk(0, 0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1)};
    tbl[2] = '{rst: 1'b0, pe: 1'b1, exp: mk(1, 0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0)};
    tbl[3] = '{rst: 1'b0, pe: 1'b0, exp: mk(1, 0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0)};
    tbl[4] = '{rst: 1'b0, pe: 1'b1, exp: mk(2, 0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0)};
    tbl[5] = '{rst: 1'b0, pe: 1'b0, exp: mk(2, 0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0)};
    tbl[6] = '{rst: 1'b1, pe: 1'b1, exp: mk(0, 0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0)};
    tbl[7] = '{rst: 1'b0, pe: 1'b0, exp: mk(0, 0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0)};
    tbl[8] = '{rst: 1'b0, pe: 1'b1, exp: mk(0, 0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1)};

    step(1'b1, 1'b0);
    step(1'b1, 1'b0);

    prev_row = rst_val;
    for (int i = 0; i < 9; i++) begin
      step(tbl[i].rst, tbl[i].pe);
      check($sformatf("table_%0d", i), get_d(), shift(tbl[i].exp, prev_row, tbl[i].rst));
      prev_row = tbl[i].exp;
    end

    // Continuous strobes over strobe positions 0..1445, then one hold cycle in the front porch.
    step(1'b1, 1'b0);
    hs_cnt = 0; act_cnt = 0; ls_cnt = 0; fs_cnt = 0; vs_cnt = 0;
    for (int i = 0; i < 1447; i++) begin
      step(1'b0, i < 1446);
      if (d_hs == 1'b0) hs_cnt++;
      if (d_act) act_cnt++;
      if (d_ls) ls_cnt++;
      if (s_fs) fs_cnt++;
      if (s_vs == 1'b1) vs_cnt++;
    end
    check_int("hs_low_count", hs_cnt, 96);
    check_int("active_count", act_cnt, 1280);
    check_int("linestart_count", ls_cnt, 2);
    check_int("small_framestart_count", fs_cnt, 3);
    check_int("small_vs_count", vs_cnt, 120);

    // Half-rate strobe: pulses must never span two clocks.
    last_ls = 1'b0; last_fs = 1'b0; last_sls = 1'b0;
    for (int i = 0; i < 400; i++) begin
      step(1'b0, (i % 2) == 0);
      check_int("pulse_len", int'((last_ls && d_ls) || (last_fs && d_fs) || (last_sls && s_ls)), 0);
      last_ls = d_ls; last_fs = d_fs; last_sls = s_ls;
    end

    for (int i = 0; i < 20000; i++) begin
      step($urandom_range(0, 2999) == 0, $urandom_range(0, 3) != 0);
    end

    // Reset mid-frame with the strobe high, then restart.
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    step(1'b1, 1'b1);
    check("mid_reset", get_d(), rst_val);
    step(1'b0, 1'b1);
    check("restart", get_d(), shift(mk(0, 0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1), rst_val, 1'b0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_sync_gen.md
Name: vga_sync_gen

Overview:
- Raster timing generator directly upstream of the VGA pixel drive stage.
- Produces the pixel coordinates (oVGA_X/oVGA_Y) that the object/draw logic uses to form the draw-pixel request.
- Also produces the active-video flag and the HSYNC/VSYNC pins for the VGA connector.
- Default timing is 640x480 @ 60 Hz, stepped by a pixel-enable strobe derived from the system clock.

Parameters:
H_VISIBLE, 640, visible pixels per line
H_FRONT, 16, horizontal front porch (pixels)
H_SYNC, 96, horizontal sync width (pixels)
H_BACK, 48, horizontal back porch (pixels)
V_VISIBLE, 480, visible lines per frame
V_FRONT, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BACK, 33, vertical back porch (lines)
SYNC_ACTIVE, 0, asserted level of oHS/oVS (0 = active-low)

Ports:
iVGA_CLK  in  1  system/pixel-domain clock, all logic on rising edge
iRST  in  1  synchronous reset, active-high
iPixEn  in  1  pixel strobe; counters advance only on cycles where it is high
oVGA_X  out  10  current column, 0..H_TOTAL-1
oVGA_Y  out  10  current row, 0..V_TOTAL-1
oActive  out  1  high when X<H_VISIBLE and Y<V_VISIBLE
oHS  out  1  horizontal sync, level per SYNC_ACTIVE
oVS  out  1  vertical sync, level per SYNC_ACTIVE
oLineStart  out  1  one-cycle pulse when X becomes 0
oFrameStart  out  1  one-cycle pulse when (X,Y) becomes (0,0)

Behaviour:
- One clock (iVGA_CLK); reset is synchronous and active-high (iRST). No other clock domains.
- H_TOTAL = sum of the four H parameters (800). V_TOTAL = sum of the four V parameters (525).
- Internal counters hcnt and vcnt, each 10 bits.
- Reset:
  - hcnt = H_TOTAL-1, vcnt = V_TOTAL-1.
  - oVGA_X = 0, oVGA_Y = 0, oActive = 0, oLineStart = 0, oFrameStart = 0.
  - oHS and oVS at the deasserted level (!SYNC_ACTIVE).
- Counter stepping, on each clock with iPixEn=1:
  - hcnt wraps H_TOTAL-1 -> 0; otherwise hcnt+1.
  - vcnt advances only when hcnt wraps; it wraps V_TOTAL-1 -> 0.
- Hold: with iPixEn=0, counters and all level outputs hold their values, and oLineStart/oFrameStart are 0.
- First strobe: the first iPixEn after reset moves to (0,0) and pulses both oLineStart and oFrameStart.
- Outputs are registered and describe the new counter value in the same clock edge that loads it, i.e. zero added latency between oVGA_X/oVGA_Y and the flags.
- Horizontal regions, decoded on the new hcnt (the horizontal state machine):
  - ACTIVE: 0..H_VISIBLE-1
  - FRONT: H_VISIBLE..H_VISIBLE+H_FRONT-1
  - SYNC: next H_SYNC counts (656..751 at defaults); oHS asserted only here
  - BACK: remaining counts to H_TOTAL-1
- Vertical regions use the same scheme on vcnt. oVS is asserted for lines 490..491 at defaults.
- Reset asserted mid-frame: reset wins over iPixEn in the same cycle, and all outputs return to their reset values on the next edge.
- Arithmetic: all compares are unsigned 10-bit. Parameters must satisfy H_TOTAL ≤ 1024 and V_TOTAL ≤ 1024.

Optional Feature:
- Macro: VGA_SYNC_DELAY_EN.
- Defined:
  - oHS, oVS and oActive each pass through one extra register stage, clocked every iVGA_CLK cycle and not gated by iPixEn.
  - This aligns them with the drive stage's one-cycle registered RGB output.
  - The extra registers reset to the same deasserted values as above.
  - oVGA_X, oVGA_Y, oLineStart and oFrameStart are not delayed.
- Undefined: no extra stage; oHS, oVS and oActive are coincident with oVGA_X/oVGA_Y.

Test Plan:
- Reset, then iPixEn=1 every cycle:
  - First edge gives X=0, Y=0, oActive=1, oLineStart=1, oFrameStart=1.
  - Next edge gives X=1, both pulses 0.
- iPixEn=1 constantly, one line:
  - oActive=1 for X=0..639 and 0 for X=640..799.
  - oHS=0 exactly for X=656..751 (96 strobes).
  - Next strobe after X=799 gives X=0, Y=1, oLineStart=1.
- Full frame, 420000 strobes:
  - oVS=0 only on Y=490..491 (1600 strobes).
  - oFrameStart pulses once, on the wrap from (799,524) to (0,0).
- iPixEn toggling 1,0,1,0 (50 MHz to 25 MHz):
  - X increments only on strobe cycles and holds on the others.
  - Pulses never last 2 clocks.
- iRST=1 while at (700,300) with iPixEn=1:
  - Next edge gives X=0, Y=0, oActive=0, oHS=1, oVS=1.
  - First strobe after reset releases gives (0,0) with oFrameStart=1.
- With VGA_SYNC_DELAY_EN defined:
  - oHS falls one iVGA_CLK after X becomes 656.
  - oActive falls one iVGA_CLK after X becomes 640.
